// File: rtl/synth_pkg.sv
// Shared synth-engine types: packer FSM states and the default signed voice sample.
package synth_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    PK_IDLE    = 2'd0,
    PK_COLLECT = 2'd1,
    PK_EMIT    = 2'd2
  } packer_state_t;

  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] voice_sample_t;

endpackage

// File: rtl/voice_frame_packer.sv
// Gathers one sample per voice from the time-multiplexed engine and emits a
// flattened NUM_VOICES frame with a one-cycle frame_valid, once per sample_tick.
module voice_frame_packer
  import synth_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_VOICES = 8,
  parameter int MISS_W     = 8,
  localparam int IDX_W     = $clog2(NUM_VOICES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sample_tick,
  output logic                         voice_req,
  input  logic                         voice_valid,
  output logic                         voice_ready,
  input  logic [IDX_W-1:0]             voice_idx,
  input  logic [DATA_WIDTH-1:0]        voice_sample,
  output logic [DATA_WIDTH*NUM_VOICES-1:0] voice_out_flat,
  output logic                         frame_valid,
  output logic                         dup_err,
  output logic [MISS_W-1:0]            miss_count,
  input  logic                         err_clr,
  output logic [1:0]                   state_dbg
);

  // Handshake: a sample transfers on a rising edge where voice_valid && voice_ready.
  // voice_ready decodes the registered state only; the producer holds idx/sample
  // stable while voice_valid && !voice_ready.

  packer_state_t               state_q, state_d;
  logic [NUM_VOICES-1:0]       mask_q, mask_hit, mask_next;
  logic [DATA_WIDTH-1:0]       buf_q [NUM_VOICES];
  logic                        pending_q;
  logic                        accept, start_frame, leave_emit, miss_inc, set_pend;

  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PK_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    voice_ready = 1'b0;
    accept      = 1'b0;
    start_frame = 1'b0;
    leave_emit  = 1'b0;
    miss_inc    = 1'b0;
    set_pend    = 1'b0;
    mask_hit    = NUM_VOICES'(1) << voice_idx;
    mask_next   = mask_q;
    case (state_q)
      PK_IDLE: begin
        if (sample_tick) begin
          start_frame = 1'b1;
          state_d     = PK_COLLECT;
        end
      end
      PK_COLLECT: begin
        voice_ready = 1'b1;
        accept      = voice_valid;
        if (accept) mask_next = mask_q | mask_hit;
        if (&mask_next) state_d = PK_EMIT;
        // A tick here always starts the next frame after EMIT, even when the
        // current frame happened to complete in the same cycle.
        if (sample_tick) begin
          state_d  = PK_EMIT;
          set_pend = 1'b1;
          miss_inc = ~(&mask_next);
        end
      end
      PK_EMIT: begin
        leave_emit = 1'b1;
        if (pending_q || sample_tick) begin
          start_frame = 1'b1;
          state_d     = PK_COLLECT;
        end else begin
          state_d = PK_IDLE;
        end
      end
      default: state_d = PK_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q         <= '0;
      pending_q      <= 1'b0;
      voice_req      <= 1'b0;
      frame_valid    <= 1'b0;
      voice_out_flat <= '0;
      dup_err        <= 1'b0;
      miss_count     <= '0;
      for (int i = 0; i < NUM_VOICES; i++) buf_q[i] <= '0;
    end else begin
      voice_req   <= start_frame;
      frame_valid <= leave_emit;
      if (leave_emit) begin
        for (int i = 0; i < NUM_VOICES; i++)
          voice_out_flat[i*DATA_WIDTH +: DATA_WIDTH] <= buf_q[i];
      end
      if (start_frame) begin
        mask_q    <= '0;
        pending_q <= 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) buf_q[i] <= '0;
      end else if (accept) begin
        mask_q         <= mask_next;
        buf_q[voice_idx] <= voice_sample;
      end
      if (set_pend) pending_q <= 1'b1;
      if (err_clr) begin
        dup_err    <= 1'b0;
        miss_count <= '0;
      end else begin
        if (accept && |(mask_q & mask_hit)) dup_err <= 1'b1;
        if (miss_inc && miss_count != '1) miss_count <= miss_count + MISS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_voice_frame_packer.sv
// Directed bench for voice_frame_packer: table-driven frames plus hand sequences
// for incomplete frames, error clearing, mid-frame reset and a tick during EMIT.
module tb_voice_frame_packer;

  localparam int DW = 32;
  localparam int NV = 8;
  localparam int MW = 8;
  localparam int FW = DW * NV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          sample_tick = 1'b0;
  logic          voice_req;
  logic          voice_valid = 1'b0;
  logic          voice_ready;
  logic [2:0]    voice_idx = '0;
  logic [DW-1:0] voice_sample = '0;
  logic [FW-1:0] voice_out_flat;
  logic          frame_valid;
  logic          dup_err;
  logic [MW-1:0] miss_count;
  logic          err_clr = 1'b0;
  logic [1:0]    state_dbg;

  voice_frame_packer #(.DATA_WIDTH(DW), .NUM_VOICES(NV), .MISS_W(MW)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .voice_req(voice_req),
    .voice_valid(voice_valid), .voice_ready(voice_ready), .voice_idx(voice_idx),
    .voice_sample(voice_sample), .voice_out_flat(voice_out_flat),
    .frame_valid(frame_valid), .dup_err(dup_err), .miss_count(miss_count),
    .err_clr(err_clr), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int req_cnt = 0;
  int frame_cnt = 0;
  logic [FW-1:0] exp_q[$];
  logic [DW-1:0] m_slot[NV];

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (voice_req) req_cnt++;
    if (frame_valid) begin
      frame_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame: got %h expected no frame", voice_out_flat);
      end else begin
        check("frame_data", voice_out_flat, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NV; i++) m_slot[i] = '0;
  endtask

  function automatic logic [FW-1:0] model_frame();
    logic [FW-1:0] r;
    for (int i = 0; i < NV; i++) r[i*DW +: DW] = m_slot[i];
    return r;
  endfunction

  task automatic push(input logic [2:0] idx, input logic [DW-1:0] val, input int gap);
    int waited = 0;
    repeat (gap) step();
    voice_valid  = 1'b1;
    voice_idx    = idx;
    voice_sample = val;
    while (!voice_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!voice_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got voice_ready=0 expected 1 within 50 cycles (idx %0d)", idx);
      voice_valid = 1'b0;
      return;
    end
    step();
    voice_valid = 1'b0;
    m_slot[idx] = val;
  endtask

  task automatic expect_emit();
    exp_q.push_back(model_frame());
    check("fv_before", frame_valid, 0);
    step();
    check("fv_latency", frame_valid, 1);
    step();
    check("fv_pulse", frame_valid, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          frame;
    logic [2:0]  idx;
    logic [31:0] val;
    int          gap;
    logic        exp_dup;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs[NVEC];

  int r0, f0;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    // frame 0: in-order 1..8, back-to-back
    for (int i = 0; i < 8; i++) vecs[i] = '{0, 3'(i), 32'(i + 1), 0, 1'b0};
    // frame 1: shuffled order, gaps, extreme signed values
    vecs[8]  = '{1, 3'd7, 32'h8000_0000, 0, 1'b0};
    vecs[9]  = '{1, 3'd0, 32'h7FFF_FFFF, 2, 1'b0};
    vecs[10] = '{1, 3'd5, 32'hFFFF_FFFF, 1, 1'b0};
    vecs[11] = '{1, 3'd2, 32'h0000_0001, 3, 1'b0};
    vecs[12] = '{1, 3'd6, 32'hDEAD_BEEF, 0, 1'b0};
    vecs[13] = '{1, 3'd1, 32'h8000_0001, 1, 1'b0};
    vecs[14] = '{1, 3'd4, 32'h7FFF_FFFE, 4, 1'b0};
    vecs[15] = '{1, 3'd3, 32'h1234_5678, 2, 1'b0};
    // frame 2: slot 3 written twice, last write wins
    vecs[16] = '{2, 3'd3, 32'h10, 0, 1'b0};
    vecs[17] = '{2, 3'd3, 32'h20, 1, 1'b1};
    vecs[18] = '{2, 3'd0, 32'h30, 0, 1'b1};
    vecs[19] = '{2, 3'd1, 32'h31, 0, 1'b1};
    vecs[20] = '{2, 3'd2, 32'h32, 0, 1'b1};
    vecs[21] = '{2, 3'd4, 32'h34, 0, 1'b1};
    vecs[22] = '{2, 3'd5, 32'h35, 0, 1'b1};
    vecs[23] = '{2, 3'd6, 32'h36, 0, 1'b1};
    vecs[24] = '{2, 3'd7, 32'h37, 0, 1'b1};

    // ---------------- reset ----------------
    #1 rst_n = 1'b0;
    #1;
    check("rst_flat", voice_out_flat, 0);
    check("rst_ready", voice_ready, 0);
    check("rst_req", voice_req, 0);
    check("rst_fv", frame_valid, 0);
    check("rst_dup", dup_err, 0);
    check("rst_miss", miss_count, 0);
    check("rst_state", state_dbg, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) step();
    check("idle_no_req", req_cnt, 0);
    check("idle_no_frame", frame_cnt, 0);
    check("idle_ready", voice_ready, 0);

    // ---------------- table-driven frames ----------------
    for (int v = 0; v < NVEC; v++) begin
      if (v == 0 || vecs[v].frame != vecs[v-1].frame) begin
        model_clear();
        r0 = req_cnt;
        f0 = frame_cnt;
        tick();
        check("req_after_tick", voice_req, 1);
      end
      push(vecs[v].idx, vecs[v].val, vecs[v].gap);
      check("dup_err", dup_err, vecs[v].exp_dup);
      if (v == NVEC - 1 || vecs[v+1].frame != vecs[v].frame) begin
        expect_emit();
        check("ready_after_frame", voice_ready, 0);
        check("frame_count", frame_cnt - f0, 1);
        check("req_count", req_cnt - r0, 1);
      end
    end

    // ---------------- incomplete frame, tick while collecting ----------------
    model_clear();
    tick();
    for (int i = 0; i < 6; i++) push(3'(i), 32'hA0 + 32'(i), 0);
    tick();
    check("miss_count_1", miss_count, 1);
    check("ready_in_emit", voice_ready, 0);
    exp_q.push_back(model_frame());
    r0 = req_cnt;
    step();
    check("miss_fv", frame_valid, 1);
    check("miss_slot67", voice_out_flat[FW-1:6*DW], 0);
    check("miss_req", voice_req, 1);
    check("miss_resume_ready", voice_ready, 1);
    model_clear();
    for (int i = 0; i < 8; i++) push(3'(i), 32'h100 + 32'(i), 0);
    expect_emit();
    check("miss_req_count", req_cnt - r0, 1);
    check("miss_count_hold", miss_count, 1);

    // ---------------- err_clr ----------------
    check("dup_sticky", dup_err, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_dup", dup_err, 0);
    check("clr_miss", miss_count, 0);

    // err_clr wins over a same-cycle miss increment
    model_clear();
    tick();
    push(3'd1, 32'h55, 0);
    push(3'd6, 32'h66, 1);
    sample_tick = 1'b1;
    err_clr = 1'b1;
    step();
    sample_tick = 1'b0;
    err_clr = 1'b0;
    check("clr_priority_miss", miss_count, 0);
    exp_q.push_back(model_frame());
    step();
    check("prio_fv", frame_valid, 1);
    model_clear();
    for (int i = 0; i < 8; i++) push(3'(i), 32'h200 + 32'(i), 0);
    expect_emit();

    // ---------------- reset mid-frame ----------------
    model_clear();
    tick();
    for (int i = 0; i < 4; i++) push(3'(i), 32'h300 + 32'(i), 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_flat", voice_out_flat, 0);
    check("mid_rst_ready", voice_ready, 0);
    check("mid_rst_state", state_dbg, 0);
    f0 = frame_cnt;
    r0 = req_cnt;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();
    check("mid_rst_no_frame", frame_cnt - f0, 0);
    check("mid_rst_no_req", req_cnt - r0, 0);
    check("mid_rst_flat_hold", voice_out_flat, 0);

    // full frame after reset, then a tick landing in EMIT
    model_clear();
    tick();
    for (int i = 0; i < 8; i++) push(3'(i), 32'h400 + 32'(i), 0);
    exp_q.push_back(model_frame());
    r0 = req_cnt;
    check("emit_state", state_dbg, 2);
    tick();
    check("emit_tick_fv", frame_valid, 1);
    check("emit_tick_ready", voice_ready, 1);
    check("emit_tick_req", voice_req, 1);
    model_clear();
    for (int i = 7; i >= 0; i--) push(3'(i), 32'h500 + 32'(i), 0);
    expect_emit();
    check("emit_tick_req_count", req_cnt - r0, 1);

    repeat (3) step();
    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
